// File: rtl/pmod1553_phy_ctrl_if.sv
// Encoder-side bundle of pmod1553_phy_ctrl: transmit request/data, loopback, fault and receive data.
// Latency: none, this is wiring only.
// Flow control: the encoder may drive tx_diff only while the matching tx_ready bit is high.
interface pmod1553_phy_ctrl_if #(
   parameter int CHANNELS = 1
);
   logic [CHANNELS-1:0]   tx_active;
   logic [2*CHANNELS-1:0] tx_diff;
   logic [CHANNELS-1:0]   tx_ready;
   logic [CHANNELS-1:0]   loopback;
   logic [CHANNELS-1:0]   fault_clr;
   logic [CHANNELS-1:0]   fault;
   logic [2*CHANNELS-1:0] rx_diff;

   // Encoder/decoder side
   modport master (
      output tx_active, tx_diff, loopback, fault_clr,
      input  tx_ready, fault, rx_diff
   );

   // Pin controller side
   modport slave (
      input  tx_active, tx_diff, loopback, fault_clr,
      output tx_ready, fault, rx_diff
   );
endinterface

// File: rtl/pmod1553_phy_ctrl.sv
// Per-channel PMOD 1553 pin controller: rx sync/glitch filter, tx enable sequencing, rx blanking, loopback, babble timeout.
// Latency: tx_diff to pads 1 cycle; pads to rx_diff 2 + RX_FILTER + 1 cycles (3 when RX_FILTER is 0).
// Backpressure: tx_ready stays low until the TX_LEAD guard has elapsed; the encoder holds data until then.
module pmod1553_phy_ctrl #(
   parameter int CHANNELS  = 1,
   parameter int TX_LEAD   = 10,
   parameter int TX_TAIL   = 10,
   parameter int RX_BLANK  = 20,
   parameter int RX_FILTER = 3,
   parameter int TX_MAX    = 80000
) (
   input  logic                clk_100mhz,
   input  logic                resetn,
   pmod1553_phy_ctrl_if.slave  enc,
   input  logic [CHANNELS-1:0] pmod_rx_p,
   input  logic [CHANNELS-1:0] pmod_rx_n,
   output logic [CHANNELS-1:0] pmod_tx_p,
   output logic [CHANNELS-1:0] pmod_tx_n,
   output logic [CHANNELS-1:0] pmod_tx_en
);
   localparam int MAX_AB = (TX_LEAD > TX_TAIL) ? TX_LEAD : TX_TAIL;
   localparam int MAX_CD = (RX_BLANK > TX_MAX) ? RX_BLANK : TX_MAX;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);
   localparam int FW     = (RX_FILTER < 1) ? 1 : $clog2(RX_FILTER + 1);

   // Counter value on the last cycle of each phase; a zero-length phase still lasts one cycle
   localparam logic [CW-1:0] LEAD_LAST  = CW'((TX_LEAD  > 0) ? TX_LEAD  - 1 : 0);
   localparam logic [CW-1:0] TAIL_LAST  = CW'((TX_TAIL  > 0) ? TX_TAIL  - 1 : 0);
   localparam logic [CW-1:0] BLANK_LAST = CW'((RX_BLANK > 0) ? RX_BLANK - 1 : 0);
   localparam logic [CW-1:0] MAX_LAST   = CW'((TX_MAX   > 0) ? TX_MAX   - 1 : 0);

   // The sample that reloads the candidate already counts as the first stable cycle
   localparam logic [FW-1:0] FLT_LAST   = FW'((RX_FILTER > 0) ? RX_FILTER - 1 : 0);
   localparam logic [FW-1:0] FLT_RELOAD = FW'((RX_FILTER >= 2) ? 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LEAD, ST_TX, ST_TAIL, ST_BLANK, ST_FAULT
   } state_t;

   logic [CHANNELS-1:0]   ready_all;
   logic [CHANNELS-1:0]   fault_all;
   logic [2*CHANNELS-1:0] rx_all;

   assign enc.tx_ready = ready_all;
   assign enc.fault    = fault_all;
   assign enc.rx_diff  = rx_all;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lb_q, lb_d;
      logic          en_q, en_d;
      logic [1:0]    pins_q, pins_d;
      logic          ready_q, ready_d;
      logic          fault_q, fault_d;
      logic [1:0]    rx_q, rx_d;
      logic [1:0]    sync1_q, sync1_d;
      logic [1:0]    sync2_q, sync2_d;
      logic [1:0]    cand_q, cand_d;
      logic [FW-1:0] fcnt_q, fcnt_d;
      logic [1:0]    filt_q, filt_d;
      logic          tx_act;
      logic [1:0]    tx_pair;
      logic [1:0]    rx_filt;

      assign tx_act  = enc.tx_active[c];
      assign tx_pair = enc.tx_diff[2*c +: 2];
      assign rx_filt = (RX_FILTER == 0) ? sync2_q : filt_q;

      // State register: phase, phase counter and loopback mode frozen for the message
      always_ff @(posedge clk_100mhz) begin
         if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lb_q    <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lb_q    <= lb_d;
         end
      end

      // Next-state: guard-time sequencing, timeout and fault recovery
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q + CW'(1);
         lb_d    = lb_q;
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (tx_act) begin
                  state_d = ST_LEAD;
                  lb_d    = enc.loopback[c];
               end
            end
            ST_LEAD: begin
               if (cnt_q == LEAD_LAST) begin
                  state_d = ST_TX;
                  cnt_d   = '0;
               end
            end
            ST_TX: begin
               // End of message takes priority over a timeout in the same cycle
               if (!tx_act) begin
                  state_d = ST_TAIL;
                  cnt_d   = '0;
               end else if (cnt_q == MAX_LAST) begin
                  state_d = ST_FAULT;
                  cnt_d   = '0;
               end
            end
            ST_TAIL: begin
               if (cnt_q == TAIL_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
               end
            end
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
            ST_FAULT: begin
               cnt_d = '0;
               if (enc.fault_clr[c] && !tx_act) begin
                  state_d = ST_BLANK;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // Output decode from the current phase; every pad and status output is registered
      always_comb begin
         en_d    = 1'b0;
         pins_d  = 2'b00;
         ready_d = 1'b0;
         fault_d = 1'b0;
         rx_d    = 2'b00;
         case (state_q)
            ST_IDLE: rx_d = rx_filt;
            ST_LEAD: en_d = !lb_q;
            ST_TX: begin
               en_d    = !lb_q;
               ready_d = 1'b1;
               if (lb_q) begin
                  rx_d = tx_pair;
               end else begin
                  pins_d = tx_pair;
               end
            end
            ST_TAIL:  en_d    = !lb_q;
            ST_FAULT: fault_d = 1'b1;
            default: begin
            end
         endcase
      end

      // Output registers
      always_ff @(posedge clk_100mhz) begin
         if (!resetn) begin
            en_q    <= 1'b0;
            pins_q  <= 2'b00;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            rx_q    <= 2'b00;
         end else begin
            en_q    <= en_d;
            pins_q  <= pins_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            rx_q    <= rx_d;
         end
      end

      // Receive synchroniser and stability filter; runs through blanking so the first unblanked value is clean
      always_comb begin
         sync1_d = {pmod_rx_n[c], pmod_rx_p[c]};
         sync2_d = sync1_q;
         cand_d  = cand_q;
         fcnt_d  = fcnt_q;
         filt_d  = filt_q;
         if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            fcnt_d = FLT_RELOAD;
         end else if (fcnt_q == FLT_LAST) begin
            filt_d = cand_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end

      // Receive path registers
      always_ff @(posedge clk_100mhz) begin
         if (!resetn) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            cand_q  <= 2'b00;
            fcnt_q  <= '0;
            filt_q  <= 2'b00;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            fcnt_q  <= fcnt_d;
            filt_q  <= filt_d;
         end
      end

      assign ready_all[c]       = ready_q;
      assign fault_all[c]       = fault_q;
      assign rx_all[2*c +: 2]   = rx_q;
      assign pmod_tx_p[c]       = pins_q[0];
      assign pmod_tx_n[c]       = pins_q[1];
      assign pmod_tx_en[c]      = en_q;
   end

endmodule

// File: tb/tb_pmod1553_phy_ctrl.sv
// Directed bench for pmod1553_phy_ctrl: a 2-channel default instance and a 1-channel short-timeout, unfiltered instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_pmod1553_phy_ctrl;
   logic clk;
   logic resetn;
   int   cyc;
   int   checks = 0;
   int   errors = 0;

   logic [1:0] d_rx_p, d_rx_n, d_tx_p, d_tx_n, d_tx_en;
   logic [0:0] t_rx_p, t_rx_n, t_tx_p, t_tx_n, t_tx_en;

   pmod1553_phy_ctrl_if #(.CHANNELS(2)) dut_if ();
   pmod1553_phy_ctrl_if #(.CHANNELS(1)) tmo_if ();

   pmod1553_phy_ctrl #(.CHANNELS(2)) u_dut (
      .clk_100mhz (clk),
      .resetn     (resetn),
      .enc        (dut_if),
      .pmod_rx_p  (d_rx_p),
      .pmod_rx_n  (d_rx_n),
      .pmod_tx_p  (d_tx_p),
      .pmod_tx_n  (d_tx_n),
      .pmod_tx_en (d_tx_en)
   );

   pmod1553_phy_ctrl #(.CHANNELS(1), .TX_MAX(100), .RX_FILTER(0)) u_tmo (
      .clk_100mhz (clk),
      .resetn     (resetn),
      .enc        (tmo_if),
      .pmod_rx_p  (t_rx_p),
      .pmod_rx_n  (t_rx_n),
      .pmod_tx_p  (t_tx_p),
      .pmod_tx_n  (t_tx_n),
      .pmod_tx_en (t_tx_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after edge n
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   initial begin
      logic [15:0] pat;
      logic        p;
      pat    = 16'hAAAA;
      resetn = 1'b0;
      d_rx_p = '0;
      d_rx_n = '0;
      t_rx_p = '0;
      t_rx_n = '0;
      dut_if.tx_active = '0;
      dut_if.tx_diff   = '0;
      dut_if.loopback  = '0;
      dut_if.fault_clr = '0;
      tmo_if.tx_active = '0;
      tmo_if.tx_diff   = '0;
      tmo_if.loopback  = '0;
      tmo_if.fault_clr = '0;
      cyc = 0;

      // Reset state
      goto(5);
      chk2("rst_en", d_tx_en, 2'b00);
      chk2("rst_tx_p", d_tx_p, 2'b00);
      chk2("rst_tx_n", d_tx_n, 2'b00);
      chk2("rst_ready", dut_if.tx_ready, 2'b00);
      chk2("rst_fault", dut_if.fault, 2'b00);
      chk2("rst_rx0", dut_if.rx_diff[1:0], 2'b00);
      chk2("rst_rx1", dut_if.rx_diff[3:2], 2'b00);
      chk1("rst_tmo_en", t_tx_en[0], 1'b0);
      chk1("rst_tmo_fault", tmo_if.fault[0], 1'b0);
      resetn = 1'b1;
      goto(8);

      // Basic transmit on channel 0, request sampled at edge 0, release sampled at edge 200
      cyc = -1;
      dut_if.tx_active[0] = 1'b1;
      goto(0);   chk1("bas_en_k0", d_tx_en[0], 1'b0);
      goto(1);   chk1("bas_en_k1", d_tx_en[0], 1'b1);
                 chk1("bas_ready_k1", dut_if.tx_ready[0], 1'b0);
      goto(10);  chk1("bas_ready_10", dut_if.tx_ready[0], 1'b0);
      goto(11);  chk1("bas_ready_11", dut_if.tx_ready[0], 1'b1);
                 chk2("bas_pins_idle", {d_tx_n[0], d_tx_p[0]}, 2'b00);
      goto(50);  dut_if.tx_diff[1:0] = 2'b01;
      goto(51);  chk2("bas_pins_01", {d_tx_n[0], d_tx_p[0]}, 2'b01);
                 dut_if.tx_diff[1:0] = 2'b10;
      goto(52);  chk2("bas_pins_10", {d_tx_n[0], d_tx_p[0]}, 2'b10);
                 chk2("bas_rx0_blank", dut_if.rx_diff[1:0], 2'b00);
                 dut_if.tx_diff[1:0] = 2'b00;
      // Channel 1 receives while channel 0 transmits
      goto(100); d_rx_p[0] = 1'b1;
                 d_rx_n[1] = 1'b1;
      goto(105); chk2("ch1_rx_105", dut_if.rx_diff[3:2], 2'b00);
      goto(106); chk2("ch1_rx_106", dut_if.rx_diff[3:2], 2'b10);
                 chk1("ch1_en_idle", d_tx_en[1], 1'b0);
      goto(199); dut_if.tx_active[0] = 1'b0;
      goto(200); chk1("bas_ready_200", dut_if.tx_ready[0], 1'b1);
      goto(201); chk1("bas_ready_201", dut_if.tx_ready[0], 1'b0);
                 chk1("bas_en_201", d_tx_en[0], 1'b1);
      goto(210); chk1("bas_en_210", d_tx_en[0], 1'b1);
      goto(211); chk1("bas_en_211", d_tx_en[0], 1'b0);
      goto(230); chk2("bas_rx0_230", dut_if.rx_diff[1:0], 2'b00);
      goto(231); chk2("bas_rx0_231", dut_if.rx_diff[1:0], 2'b01);

      // Receive filter: a 2-cycle glitch is rejected, a stable level appears 6 cycles later
      goto(240); d_rx_p[0] = 1'b0;
      goto(260); chk2("flt_rx_low", dut_if.rx_diff[1:0], 2'b00);
                 d_rx_p[0] = 1'b1;
      goto(262); d_rx_p[0] = 1'b0;
      goto(263); chk2("flt_glitch_263", dut_if.rx_diff[1:0], 2'b00);
      goto(266); chk2("flt_glitch_266", dut_if.rx_diff[1:0], 2'b00);
      goto(272); chk2("flt_glitch_272", dut_if.rx_diff[1:0], 2'b00);
      goto(280); d_rx_p[0] = 1'b1;
      goto(285); chk2("flt_stable_285", dut_if.rx_diff[1:0], 2'b00);
      goto(286); chk2("flt_stable_286", dut_if.rx_diff[1:0], 2'b01);

      // Loopback on channel 0 with a concurrent normal transmit on channel 1
      goto(290);
      cyc = -1;
      dut_if.tx_active[0] = 1'b1;
      dut_if.loopback[0]  = 1'b1;
      goto(2);   dut_if.tx_active[1] = 1'b1;
      goto(4);   chk1("ch1_en_4", d_tx_en[1], 1'b1);
      goto(5);   chk1("lb_en_lead", d_tx_en[0], 1'b0);
      goto(11);  chk1("lb_ready_11", dut_if.tx_ready[0], 1'b1);
                 chk1("lb_en_11", d_tx_en[0], 1'b0);
      goto(12);  dut_if.loopback[0] = 1'b0;
      goto(13);  chk1("ch1_ready_13", dut_if.tx_ready[1], 1'b0);
      goto(14);  chk1("ch1_ready_14", dut_if.tx_ready[1], 1'b1);
      goto(20);
      for (int i = 0; i < 32; i++) begin
         p = ((i % 2) == 0) ? pat[15 - i/2] : ~pat[15 - i/2];
         dut_if.tx_diff = {~p, p, ~p, p};
         goto(cyc + 1);
         chk2("lb_rx0", dut_if.rx_diff[1:0], {~p, p});
         chk2("lb_pins0", {d_tx_n[0], d_tx_p[0]}, 2'b00);
         chk1("lb_en0", d_tx_en[0], 1'b0);
         chk2("ch1_pins", {d_tx_n[1], d_tx_p[1]}, {~p, p});
         chk2("ch1_rx_blank", dut_if.rx_diff[3:2], 2'b00);
      end
      dut_if.tx_diff = '0;
      goto(60);  dut_if.tx_active[0] = 1'b0;
      goto(61);  chk1("lb_ready_61", dut_if.tx_ready[0], 1'b1);
      goto(62);  chk1("lb_ready_62", dut_if.tx_ready[0], 1'b0);
                 chk2("lb_rx0_tail", dut_if.rx_diff[1:0], 2'b00);
      goto(65);  chk1("lb_en_tail", d_tx_en[0], 1'b0);
      goto(70);  dut_if.tx_active[1] = 1'b0;
      goto(81);  chk1("ch1_en_81", d_tx_en[1], 1'b1);
      goto(82);  chk1("ch1_en_82", d_tx_en[1], 1'b0);
      goto(91);  chk2("lb_rx0_91", dut_if.rx_diff[1:0], 2'b00);
      goto(92);  chk2("lb_rx0_92", dut_if.rx_diff[1:0], 2'b01);
      goto(101); chk2("ch1_rx_101", dut_if.rx_diff[3:2], 2'b00);
      goto(102); chk2("ch1_rx_102", dut_if.rx_diff[3:2], 2'b10);

      // Reset in the middle of a transmit, then a fresh request runs the full lead
      goto(110);
      cyc = -1;
      dut_if.tx_active[0]  = 1'b1;
      dut_if.tx_diff[1:0]  = 2'b01;
      goto(15);  chk2("mrst_pins_pre", {d_tx_n[0], d_tx_p[0]}, 2'b01);
                 chk1("mrst_ready_pre", dut_if.tx_ready[0], 1'b1);
                 resetn = 1'b0;
      goto(16);  chk2("mrst_en", d_tx_en, 2'b00);
                 chk2("mrst_pins", {d_tx_n[0], d_tx_p[0]}, 2'b00);
                 chk2("mrst_ready", dut_if.tx_ready, 2'b00);
                 chk2("mrst_fault", dut_if.fault, 2'b00);
                 chk2("mrst_rx0", dut_if.rx_diff[1:0], 2'b00);
                 chk2("mrst_rx1", dut_if.rx_diff[3:2], 2'b00);
                 resetn = 1'b1;
      goto(17);  chk1("mrst_en_17", d_tx_en[0], 1'b0);
      goto(18);  chk1("mrst_en_18", d_tx_en[0], 1'b1);
      goto(27);  chk1("mrst_ready_27", dut_if.tx_ready[0], 1'b0);
      goto(28);  chk1("mrst_ready_28", dut_if.tx_ready[0], 1'b1);
                 dut_if.tx_active[0] = 1'b0;
                 dut_if.tx_diff      = '0;

      // Unfiltered receive latency on the timeout instance
      goto(40);
      cyc = 0;
      t_rx_p[0] = 1'b1;
      goto(2);   chk2("byp_rx_2", tmo_if.rx_diff, 2'b00);
      goto(3);   chk2("byp_rx_3", tmo_if.rx_diff, 2'b01);

      // Babbling transmitter timeout, clear handshake, and fall-versus-timeout tie
      goto(9);
      cyc = -1;
      tmo_if.tx_active[0] = 1'b1;
      goto(110); chk1("tmo_fault_110", tmo_if.fault[0], 1'b0);
                 chk1("tmo_en_110", t_tx_en[0], 1'b1);
      goto(111); chk1("tmo_fault_111", tmo_if.fault[0], 1'b1);
                 chk1("tmo_en_111", t_tx_en[0], 1'b0);
                 chk1("tmo_ready_111", tmo_if.tx_ready[0], 1'b0);
      goto(115); tmo_if.fault_clr[0] = 1'b1;
      goto(120); chk1("tmo_clr_held", tmo_if.fault[0], 1'b1);
                 tmo_if.tx_active[0] = 1'b0;
      goto(121); chk1("tmo_fault_121", tmo_if.fault[0], 1'b1);
      goto(122); chk1("tmo_fault_122", tmo_if.fault[0], 1'b0);
                 tmo_if.fault_clr[0] = 1'b0;
      goto(141); chk2("tmo_rx_141", tmo_if.rx_diff, 2'b00);
      goto(142); chk2("tmo_rx_142", tmo_if.rx_diff, 2'b01);
                 tmo_if.tx_active[0] = 1'b1;
      goto(143); chk1("tmo_en_143", t_tx_en[0], 1'b0);
      goto(144); chk1("tmo_en_144", t_tx_en[0], 1'b1);
      goto(252); tmo_if.tx_active[0] = 1'b0;
      goto(253); chk1("tie_ready_253", tmo_if.tx_ready[0], 1'b1);
      goto(254); chk1("tie_fault_254", tmo_if.fault[0], 1'b0);
                 chk1("tie_en_254", t_tx_en[0], 1'b1);
                 chk1("tie_ready_254", tmo_if.tx_ready[0], 1'b0);
      goto(270); chk1("tie_fault_270", tmo_if.fault[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
